// File: rtl/transmisor_pkg.sv
// Shared symbol, control-code and FSM definitions for the lane transmitter.
package transmisor_pkg;

  // Physical-layer symbol bytes
  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] SYM_STP  = 8'hFB;
  localparam logic [7:0] SYM_SDP  = 8'h5C;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_EDB  = 8'hFE;
  localparam logic [7:0] SYM_FTS  = 8'h3C;
  localparam logic [7:0] SYM_IDLE = 8'h7C;

  // control_dk codes
  localparam logic [3:0] CTRL_DATA = 4'b0000;
  localparam logic [3:0] CTRL_COM  = 4'b0001;
  localparam logic [3:0] CTRL_SKP  = 4'b0010;
  localparam logic [3:0] CTRL_STP  = 4'b0011;
  localparam logic [3:0] CTRL_SDP  = 4'b0100;
  localparam logic [3:0] CTRL_END  = 4'b0101;
  localparam logic [3:0] CTRL_EDB  = 4'b0110;
  localparam logic [3:0] CTRL_FTS  = 4'b0111;
  localparam logic [3:0] CTRL_IDLE = 4'b1000;

  // FSM state encoding
  localparam logic [1:0] ST_DATA    = 2'd0;
  localparam logic [1:0] ST_SKP_COM = 2'd1;
  localparam logic [1:0] ST_SKP_SYM = 2'd2;

  // One lane symbol: K flag plus byte
  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } sym_t;

  // Packet framing helpers
  function automatic logic is_pkt_start(input logic [3:0] code);
    return (code == CTRL_STP) || (code == CTRL_SDP);
  endfunction

  function automatic logic is_pkt_end(input logic [3:0] code);
    return (code == CTRL_END) || (code == CTRL_EDB);
  endfunction

endpackage

// File: rtl/transmisor_param_tx_symbol_mux.sv
// Maps a control code (or raw data byte) to the lane symbol and its K flag.
module tx_symbol_mux
  import transmisor_pkg::*;
(
  input  logic [7:0] tx_data,
  input  logic [3:0] control_dk,
  output sym_t       sym_c
);

  // Symbol lookup; every non-data code is a K symbol, unused codes fall back to IDLE
  always_comb begin
    sym_c.k    = 1'b1;
    sym_c.data = SYM_IDLE;
    case (control_dk)
      CTRL_DATA: begin
        sym_c.k    = 1'b0;
        sym_c.data = tx_data;
      end
      CTRL_COM:  sym_c.data = SYM_COM;
      CTRL_SKP:  sym_c.data = SYM_SKP;
      CTRL_STP:  sym_c.data = SYM_STP;
      CTRL_SDP:  sym_c.data = SYM_SDP;
      CTRL_END:  sym_c.data = SYM_END;
      CTRL_EDB:  sym_c.data = SYM_EDB;
      CTRL_FTS:  sym_c.data = SYM_FTS;
      default:   sym_c.data = SYM_IDLE;
    endcase
  end

endmodule

// File: rtl/transmisor_param.sv
// Byte-to-lane striping transmitter with periodic SKP ordered-set insertion.
module transmisor_param
  import transmisor_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned SKP_INTERVAL = 64,
  parameter int unsigned SKP_LEN      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [7:0]             tx_DataE,
  input  logic [3:0]             control_dk,
  output logic [8*NUM_LANES-1:0] tx_lanes,
  output logic [NUM_LANES-1:0]   tx_k,
  output logic                   tx_lane_valid,
  output logic                   skp_active
);

  localparam int unsigned SLOT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W  = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int unsigned SKP_W  = $clog2(SKP_LEN + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [SKP_W-1:0]  SKP_LAST  = SKP_W'(SKP_LEN - 1);

  logic [1:0]             state_q,       state_d;
  logic [SLOT_W-1:0]      slot_q,        slot_d;
  logic [8*NUM_LANES-1:0] buf_lanes_q,   buf_lanes_d;
  logic [NUM_LANES-1:0]   buf_k_q,       buf_k_d;
  logic [8*NUM_LANES-1:0] tx_lanes_q,    tx_lanes_d;
  logic [NUM_LANES-1:0]   tx_k_q,        tx_k_d;
  logic                   lane_valid_q,  lane_valid_d;
  logic                   skp_active_q,  skp_active_d;
  logic [CNT_W-1:0]       word_cnt_q,    word_cnt_d;
  logic                   skp_pending_q, skp_pending_d;
  logic                   in_packet_q,   in_packet_d;
  logic [SKP_W-1:0]       skp_cnt_q,     skp_cnt_d;

  sym_t mux_sym_c;
  logic insert_c;
  logic accept_c;

  tx_symbol_mux u_symbol_mux (
    .tx_data    (tx_DataE),
    .control_dk (control_dk),
    .sym_c      (mux_sym_c)
  );

  // Handshake: ordered-set insertion waits for a word boundary outside a packet
  always_comb begin
    insert_c = skp_pending_q && (slot_q == '0) && !in_packet_q;
    tx_ready = enb && !rst && (state_q == ST_DATA) && !insert_c;
    accept_c = tx_valid && tx_ready;
  end

  // Next-state: word assembly, SKP scheduling and ordered-set emission
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    buf_lanes_d   = buf_lanes_q;
    buf_k_d       = buf_k_q;
    tx_lanes_d    = tx_lanes_q;
    tx_k_d        = tx_k_q;
    lane_valid_d  = 1'b0;
    skp_active_d  = 1'b0;
    word_cnt_d    = word_cnt_q;
    skp_pending_d = skp_pending_q;
    in_packet_d   = in_packet_q;
    skp_cnt_d     = skp_cnt_q;

    if (enb) begin
      unique case (state_q)
        ST_DATA: begin
          if (insert_c) begin
            state_d = ST_SKP_COM;
          end else if (accept_c) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              if (slot_q == SLOT_W'(i)) begin
                buf_lanes_d[8*i +: 8] = mux_sym_c.data;
                buf_k_d[i]            = mux_sym_c.k;
              end
            end
            if (is_pkt_start(control_dk)) begin
              in_packet_d = 1'b1;
            end else if (is_pkt_end(control_dk)) begin
              in_packet_d = 1'b0;
            end
            if (slot_q == LAST_SLOT) begin
              slot_d       = '0;
              tx_lanes_d   = buf_lanes_d;
              tx_k_d       = buf_k_d;
              lane_valid_d = 1'b1;
              if (word_cnt_q == CNT_MAX) begin
                skp_pending_d = 1'b1;
              end else begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
              end
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        ST_SKP_COM: begin
          tx_lanes_d   = {NUM_LANES{SYM_COM}};
          tx_k_d       = '1;
          lane_valid_d = 1'b1;
          skp_active_d = 1'b1;
          skp_cnt_d    = '0;
          state_d      = ST_SKP_SYM;
        end
        ST_SKP_SYM: begin
          tx_lanes_d   = {NUM_LANES{SYM_SKP}};
          tx_k_d       = '1;
          lane_valid_d = 1'b1;
          skp_active_d = 1'b1;
          if (skp_cnt_q == SKP_LAST) begin
            skp_cnt_d     = '0;
            state_d       = ST_DATA;
            skp_pending_d = 1'b0;
            word_cnt_d    = '0;
          end else begin
            skp_cnt_d = skp_cnt_q + SKP_W'(1);
          end
        end
        default: state_d = ST_DATA;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_DATA;
      slot_q        <= '0;
      buf_lanes_q   <= '0;
      buf_k_q       <= '0;
      tx_lanes_q    <= '0;
      tx_k_q        <= '0;
      lane_valid_q  <= 1'b0;
      skp_active_q  <= 1'b0;
      word_cnt_q    <= '0;
      skp_pending_q <= 1'b0;
      in_packet_q   <= 1'b0;
      skp_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      buf_lanes_q   <= buf_lanes_d;
      buf_k_q       <= buf_k_d;
      tx_lanes_q    <= tx_lanes_d;
      tx_k_q        <= tx_k_d;
      lane_valid_q  <= lane_valid_d;
      skp_active_q  <= skp_active_d;
      word_cnt_q    <= word_cnt_d;
      skp_pending_q <= skp_pending_d;
      in_packet_q   <= in_packet_d;
      skp_cnt_q     <= skp_cnt_d;
    end
  end

  assign tx_lanes      = tx_lanes_q;
  assign tx_k          = tx_k_q;
  assign tx_lane_valid = lane_valid_q;
  assign skp_active    = skp_active_q;

endmodule

// File: tb/tb_transmisor_param.sv
// Randomized and directed bench for transmisor_param against a cycle-level reference model.
module tb_transmisor_param;

  localparam int unsigned NL = 4;
  localparam int unsigned SI = 4;
  localparam int unsigned SL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enb = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] tx_DataE = 8'h00;
  logic [3:0] control_dk = 4'b0000;
  logic tx_ready;
  logic [8*NL-1:0] tx_lanes;
  logic [NL-1:0] tx_k;
  logic tx_lane_valid;
  logic skp_active;

  // Regression instances for 1 and 8 lanes
  logic r_enb = 1'b1;
  logic r_valid = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic [3:0] r_ctrl = 4'b0000;
  logic r_ready1, r_valid1, r_skp1;
  logic [7:0] r_lanes1;
  logic [0:0] r_k1;
  logic r_ready8, r_valid8, r_skp8;
  logic [63:0] r_lanes8;
  logic [7:0] r_k8;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [8:0] cur_q[$];
  int words_since = 0;
  bit in_pkt = 0;
  int os_left = 0;
  logic [8*NL-1:0] exp_lanes = '0;
  logic [NL-1:0] exp_k = '0;
  logic exp_valid = 1'b0;
  logic exp_skp = 1'b0;

  logic [31:0] obs_q[$];
  int skp_seen = 0;

  always #5 clk = ~clk;

  transmisor_param #(.NUM_LANES(NL), .SKP_INTERVAL(SI), .SKP_LEN(SL)) dut (
    .clk(clk), .rst(rst), .enb(enb), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_DataE(tx_DataE), .control_dk(control_dk), .tx_lanes(tx_lanes), .tx_k(tx_k),
    .tx_lane_valid(tx_lane_valid), .skp_active(skp_active)
  );

  transmisor_param #(.NUM_LANES(1), .SKP_INTERVAL(1023), .SKP_LEN(3)) dut1 (
    .clk(clk), .rst(rst), .enb(r_enb), .tx_valid(r_valid), .tx_ready(r_ready1),
    .tx_DataE(r_data), .control_dk(r_ctrl), .tx_lanes(r_lanes1), .tx_k(r_k1),
    .tx_lane_valid(r_valid1), .skp_active(r_skp1)
  );

  transmisor_param #(.NUM_LANES(8), .SKP_INTERVAL(1023), .SKP_LEN(3)) dut8 (
    .clk(clk), .rst(rst), .enb(r_enb), .tx_valid(r_valid), .tx_ready(r_ready8),
    .tx_DataE(r_data), .control_dk(r_ctrl), .tx_lanes(r_lanes8), .tx_k(r_k8),
    .tx_lane_valid(r_valid8), .skp_active(r_skp8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Symbol table: {K, byte}
  function automatic logic [8:0] map_sym(input logic [3:0] c, input logic [7:0] d);
    case (c)
      4'd0: return {1'b0, d};
      4'd1: return {1'b1, 8'hBC};
      4'd2: return {1'b1, 8'h1C};
      4'd3: return {1'b1, 8'hFB};
      4'd4: return {1'b1, 8'h5C};
      4'd5: return {1'b1, 8'hFD};
      4'd6: return {1'b1, 8'hFE};
      4'd7: return {1'b1, 8'h3C};
      default: return {1'b1, 8'h7C};
    endcase
  endfunction

  function automatic logic exp_ready();
    return !rst && enb && (os_left == 0) &&
           !((words_since >= int'(SI)) && (cur_q.size() == 0) && !in_pkt);
  endfunction

  // Advance the model by one clock edge using the current inputs
  task automatic model_step();
    logic [8:0] s;
    exp_valid = 1'b0;
    exp_skp   = 1'b0;
    if (rst) begin
      cur_q.delete();
      words_since = 0;
      in_pkt = 0;
      os_left = 0;
      exp_lanes = '0;
      exp_k = '0;
    end else if (enb) begin
      if (os_left > 0) begin
        for (int i = 0; i < int'(NL); i++)
          exp_lanes[8*i +: 8] = (os_left == int'(SL) + 1) ? 8'hBC : 8'h1C;
        exp_k = '1;
        exp_valid = 1'b1;
        exp_skp = 1'b1;
        os_left--;
        if (os_left == 0) words_since = 0;
      end else if ((words_since >= int'(SI)) && (cur_q.size() == 0) && !in_pkt) begin
        os_left = int'(SL) + 1;
      end else if (tx_valid) begin
        s = map_sym(control_dk, tx_DataE);
        cur_q.push_back(s);
        if (control_dk == 4'd3 || control_dk == 4'd4) in_pkt = 1;
        else if (control_dk == 4'd5 || control_dk == 4'd6) in_pkt = 0;
        if (cur_q.size() == int'(NL)) begin
          for (int i = 0; i < int'(NL); i++) begin
            exp_lanes[8*i +: 8] = cur_q[i][7:0];
            exp_k[i] = cur_q[i][8];
          end
          exp_valid = 1'b1;
          words_since++;
          cur_q.delete();
        end
      end
    end
  endtask

  // One clock of stimulus with ready check before the edge and output checks after
  task automatic drive_cycle(input logic r, input logic e, input logic v,
                             input logic [3:0] c, input logic [7:0] d);
    @(negedge clk);
    rst = r; enb = e; tx_valid = v; control_dk = c; tx_DataE = d;
    #1;
    check_eq("tx_ready", 64'(tx_ready), 64'(exp_ready()));
    model_step();
    @(posedge clk);
    #1;
    check_eq("tx_lane_valid", 64'(tx_lane_valid), 64'(exp_valid));
    check_eq("skp_active", 64'(skp_active), 64'(exp_skp));
    check_eq("tx_lanes", 64'(tx_lanes), 64'(exp_lanes));
    check_eq("tx_k", 64'(tx_k), 64'(exp_k));
    if (tx_lane_valid) obs_q.push_back(tx_lanes);
    if (skp_active) skp_seen++;
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b1, 1'b1, 4'd8, 8'h00);
    drive_cycle(1'b1, 1'b1, 1'b1, 4'd8, 8'h00);
    obs_q.delete();
    skp_seen = 0;
  endtask

  task automatic idle_bytes(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b1, 4'd8, 8'h00);
  endtask

  initial begin
    int idx;
    int n1, n8;
    logic [3:0] c;

    // Reset with valid asserted: outputs cleared, not ready
    do_reset();
    check_eq("reset_lanes", 64'(tx_lanes), 64'h0);
    check_eq("reset_k", 64'(tx_k), 64'h0);

    // STP,D00,D01,END framing word
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd3, 8'h00);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'h00);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'h01);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd5, 8'h00);
    check_eq("stp_end_lanes", 64'(tx_lanes), 64'hFD0100FB);
    check_eq("stp_end_k", 64'(tx_k), 64'h9);
    check_eq("stp_end_valid", 64'(tx_lane_valid), 64'h1);

    // Enable freeze mid-word
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'h11);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'h22);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, 4'd0, 8'hAA);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'h33);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'h44);
    check_eq("enb_word_lanes", 64'(tx_lanes), 64'h44332211);
    check_eq("enb_word_valid", 64'(tx_lane_valid), 64'h1);
    check_eq("enb_word_count", 64'(obs_q.size()), 64'd1);

    // Interval expiry on idle traffic: COM then SKP x3
    do_reset();
    idle_bytes(16 + 10);
    check_eq("os_skp_cycles", 64'(skp_seen), 64'd4);
    check_eq("os_word_total", 64'(obs_q.size()), 64'd9);
    if (obs_q.size() >= 8) begin
      check_eq("os_com_word", 64'(obs_q[4]), 64'hBCBCBCBC);
      check_eq("os_skp_word", 64'(obs_q[7]), 64'h1C1C1C1C);
    end

    // Interval expiry inside a packet defers the ordered set until END word
    do_reset();
    idle_bytes(12);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd3, 8'h00);
    for (int i = 1; i <= 10; i++) drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'(i));
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd5, 8'h00);
    idle_bytes(6);
    idx = -1;
    for (int i = 0; i < obs_q.size(); i++)
      if (idx < 0 && obs_q[i][31:24] == 8'hFD) idx = i;
    check_eq("defer_end_idx", 64'(idx), 64'd5);
    if (idx >= 0 && idx + 1 < obs_q.size())
      check_eq("defer_com_next", 64'(obs_q[idx+1]), 64'hBCBCBCBC);

    // Reset mid-word discards the partial word
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'hA1);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'hA2);
    drive_cycle(1'b1, 1'b1, 1'b1, 4'd0, 8'hA3);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 8'(8'hB0 + i));
    check_eq("rst_word_lanes", 64'(tx_lanes), 64'hB3B2B1B0);

    // Reset mid-ordered-set drops remaining SKP words
    do_reset();
    idle_bytes(16 + 3);
    drive_cycle(1'b1, 1'b1, 1'b1, 4'd8, 8'h00);
    idle_bytes(8);
    check_eq("rst_os_skp_cycles", 64'(skp_seen), 64'd2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 15) < 8) ? 4'd0 : 4'($urandom_range(1, 15));
      drive_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0, c, 8'($urandom));
    end

    // Lane-count regression with code 1011 (maps to IDLE)
    @(negedge clk);
    rst = 1'b0; enb = 1'b1; tx_valid = 1'b0;
    r_ctrl = 4'b1011; r_data = 8'h55;
    n1 = 0; n8 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r_valid = (i < 8);
      @(posedge clk);
      #1;
      if (r_valid1) n1++;
      if (r_valid8) n8++;
    end
    check_eq("lane1_words", 64'(n1), 64'd8);
    check_eq("lane8_words", 64'(n8), 64'd1);
    check_eq("lane1_sym", 64'(r_lanes1), 64'h7C);
    check_eq("lane1_k", 64'(r_k1), 64'h1);
    check_eq("lane8_sym", r_lanes8, 64'h7C7C7C7C7C7C7C7C);
    check_eq("lane8_k", 64'(r_k8), 64'hFF);
    check_eq("lane8_ready", 64'(r_ready8), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
